// File: rtl/index_bitmap_decoder_pkg.sv
// Shared types and width helpers for the index-to-bitmap decoder.
// The frame FSM has two states: accumulating beats, and holding a finished frame.
package index_bitmap_decoder_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Bits needed to count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/index_bitmap_decoder_onehot_decoder.sv
// Combinational index-to-one-hot decoder.
// An index with no matching bit gives an all-zero vector and in_range_o low.
module onehot_decoder #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [IDX_W-1:0] index_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic             in_range_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign onehot_o[gi] = (index_i == IDX_W'(gi));
    end
  endgenerate

  // The index is in range exactly when some bit decoded; this avoids a magnitude compare.
  assign in_range_o = |onehot_o;

endmodule

// File: rtl/index_bitmap_decoder.sv
// Rebuilds a WIDTH-bit bitmap from a stream of encoded indices, one frame per s_last.
// Each finished frame is held with its popcount and dup/err flags until m_ready.
module index_bitmap_decoder
  import index_bitmap_decoder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] s_idx,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_bitmap,
  output logic [CNT_W-1:0] m_count,
  output logic             m_dup,
  output logic             m_err,
  output logic             m_valid,
  input  logic             m_ready
);

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             dup_q, dup_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] m_bitmap_q, m_bitmap_d;
  logic [CNT_W-1:0] m_count_q, m_count_d;
  logic             m_dup_q, m_dup_d;
  logic             m_err_q, m_err_d;

  logic [WIDTH-1:0] onehot;
  logic             in_range;
  logic [WIDTH-1:0] merged;
  logic             beat_dup;
  logic             beat_err;
  logic             accept;

  onehot_decoder #(.WIDTH(WIDTH)) u_onehot (
    .index_i    (s_idx),
    .onehot_o   (onehot),
    .in_range_o (in_range)
  );

  assign merged   = acc_q | onehot;
  assign beat_dup = in_range & (|(acc_q & onehot));
  assign beat_err = ~in_range;
  assign s_ready  = (state_q == ACCUM);
  assign accept   = s_valid & s_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    dup_d      = dup_q;
    err_d      = err_q;
    m_bitmap_d = m_bitmap_q;
    m_count_d  = m_count_q;
    m_dup_d    = m_dup_q;
    m_err_d    = m_err_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (s_last) begin
            // The last beat bypasses the accumulator straight into the output registers.
            m_bitmap_d = merged;
            m_count_d  = popcount(merged);
            m_dup_d    = dup_q | beat_dup;
            m_err_d    = err_q | beat_err;
            acc_d      = '0;
            dup_d      = 1'b0;
            err_d      = 1'b0;
            state_d    = HOLD;
          end else begin
            acc_d = merged;
            dup_d = dup_q | beat_dup;
            err_d = err_q | beat_err;
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      dup_q      <= 1'b0;
      err_q      <= 1'b0;
      m_bitmap_q <= '0;
      m_count_q  <= '0;
      m_dup_q    <= 1'b0;
      m_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dup_q      <= dup_d;
      err_q      <= err_d;
      m_bitmap_q <= m_bitmap_d;
      m_count_q  <= m_count_d;
      m_dup_q    <= m_dup_d;
      m_err_q    <= m_err_d;
    end
  end

  assign m_valid  = (state_q == HOLD);
  assign m_bitmap = m_bitmap_q;
  assign m_count  = m_count_q;
  assign m_dup    = m_dup_q;
  assign m_err    = m_err_q;

endmodule

// File: tb/tb_index_bitmap_decoder.sv
// Drives one index stream into a WIDTH=8 and a WIDTH=5 decoder in parallel and
// checks each frame against a per-width reference built from the index list.
module tb_index_bitmap_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] s_idx = '0;
  logic       s_last = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;

  logic       s_ready8, m_dup8, m_err8, m_valid8;
  logic [7:0] m_bitmap8;
  logic [3:0] m_count8;
  logic       s_ready5, m_dup5, m_err5, m_valid5;
  logic [4:0] m_bitmap5;
  logic [2:0] m_count5;

  int checks = 0;
  int failures = 0;
  int frame_q[$];

  always #5 clk = ~clk;

  index_bitmap_decoder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s_idx(s_idx), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready8), .m_bitmap(m_bitmap8), .m_count(m_count8), .m_dup(m_dup8),
    .m_err(m_err8), .m_valid(m_valid8), .m_ready(m_ready)
  );

  index_bitmap_decoder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .s_idx(s_idx), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready5), .m_bitmap(m_bitmap5), .m_count(m_count5), .m_dup(m_dup5),
    .m_err(m_err5), .m_valid(m_valid5), .m_ready(m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: set of distinct in-range indices, dup if seen before, err if out of range.
  function automatic void model(input int w, input int idxs[$],
                                output int bm, output int cnt, output int dup, output int err);
    bit seen[8];
    bm = 0; cnt = 0; dup = 0; err = 0;
    foreach (seen[k]) seen[k] = 1'b0;
    foreach (idxs[k]) begin
      if (idxs[k] >= w) err = 1;
      else if (seen[idxs[k]]) dup = 1;
      else begin
        seen[idxs[k]] = 1'b1;
        bm = bm + (1 << idxs[k]);
        cnt = cnt + 1;
      end
    end
  endfunction

  // Called at #1 after a clock edge; returns at #1 after the accepting edge.
  task automatic send_beat(input int idx, input bit last);
    bit accepted = 1'b0;
    bit rdy;
    s_idx = 3'(idx);
    s_last = last;
    s_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rdy = s_ready8;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("beat_accept", 32'(accepted), 32'd1);
    frame_q.push_back(idx);
    if (!last) chk("no_early_valid", 32'(m_valid8), 32'd0);
    $display("beat idx=%0d last=%0d accepted=%0d", idx, last, accepted);
  endtask

  // Called right after the last beat's accepting edge.
  task automatic expect_frame(input string tag, input int hold);
    int bm8, cnt8, dup8, err8, bm5, cnt5, dup5, err5;
    model(8, frame_q, bm8, cnt8, dup8, err8);
    model(5, frame_q, bm5, cnt5, dup5, err5);
    chk({tag, ".valid8"}, 32'(m_valid8), 32'd1);
    chk({tag, ".valid5"}, 32'(m_valid5), 32'd1);
    chk({tag, ".bitmap8"}, 32'(m_bitmap8), 32'(bm8));
    chk({tag, ".count8"}, 32'(m_count8), 32'(cnt8));
    chk({tag, ".dup8"}, 32'(m_dup8), 32'(dup8));
    chk({tag, ".err8"}, 32'(m_err8), 32'(err8));
    chk({tag, ".bitmap5"}, 32'(m_bitmap5), 32'(bm5));
    chk({tag, ".count5"}, 32'(m_count5), 32'(cnt5));
    chk({tag, ".dup5"}, 32'(m_dup5), 32'(dup5));
    chk({tag, ".err5"}, 32'(m_err5), 32'(err5));
    chk({tag, ".s_ready_low"}, 32'({s_ready8, s_ready5}), 32'd0);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, 32'({m_valid8, m_valid5}), 32'd3);
      chk({tag, ".hold_bitmap8"}, 32'(m_bitmap8), 32'(bm8));
      chk({tag, ".hold_bitmap5"}, 32'(m_bitmap5), 32'(bm5));
      chk({tag, ".hold_s_ready"}, 32'({s_ready8, s_ready5}), 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'({m_valid8, m_valid5}), 32'd0);
    chk({tag, ".s_ready_rise"}, 32'({s_ready8, s_ready5}), 32'd3);
    $display("frame %s n=%0d w8 bm=%0h cnt=%0d dup=%0d err=%0d | w5 bm=%0h cnt=%0d dup=%0d err=%0d",
             tag, frame_q.size(), bm8, cnt8, dup8, err8, bm5, cnt5, dup5, err5);
    frame_q.delete();
  endtask

  initial begin
    int len;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'({m_valid8, m_valid5}), 32'd0);
    chk("rst.bitmap8", 32'(m_bitmap8), 32'd0);
    chk("rst.count8", 32'(m_count8), 32'd0);
    chk("rst.flags", 32'({m_dup8, m_err8, m_dup5, m_err5}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.s_ready", 32'({s_ready8, s_ready5}), 32'd3);

    send_beat(1, 0); send_beat(3, 0); send_beat(6, 1);
    expect_frame("basic", 0);
    send_beat(0, 1);
    expect_frame("single0", 0);
    send_beat(7, 1);
    expect_frame("single7", 1);
    send_beat(2, 0); send_beat(2, 0); send_beat(5, 1);
    expect_frame("dup", 0);
    send_beat(4, 0); send_beat(6, 1);
    expect_frame("range", 0);
    send_beat(7, 1);
    expect_frame("empty", 0);

    // Backpressure: an extra beat is offered while the frame is held and must be ignored.
    send_beat(0, 0); send_beat(1, 0); send_beat(2, 0); send_beat(3, 1);
    s_idx = 3'd5; s_last = 1'b0; s_valid = 1'b1;
    expect_frame("bp", 4);
    s_valid = 1'b0;
    send_beat(4, 1);
    expect_frame("after_bp", 0);

    // Reset mid-frame discards the partial accumulator.
    send_beat(3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'({m_valid8, m_valid5}), 32'd0);
    chk("midrst.bitmap8", 32'(m_bitmap8), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_q.delete();
    send_beat(0, 1);
    expect_frame("post_rst", 0);

    for (int f = 0; f < 25; f++) begin
      len = int'($urandom_range(1, 5));
      for (int b = 0; b < len; b++) begin
        send_beat(int'($urandom_range(0, 7)), (b == len - 1));
      end
      expect_frame($sformatf("rnd%0d", f), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
